// File: rtl/debounce_pkg.sv
// debounce_pkg: 25 MHz board timing constants and counter width helpers
// shared by the debounce bank and its per-channel logic.
package debounce_pkg;
    localparam int CLK_HZ        = 25_000_000;
    localparam int DEBOUNCE_10MS = CLK_HZ / 100;
    localparam int HOLD_500MS    = CLK_HZ / 2;
    localparam int REPEAT_100MS  = CLK_HZ / 10;

    function automatic int CNT_W(input int limit);
        return $clog2(limit + 1);
    endfunction

    function automatic int HOLD_W(input int limit);
        return $clog2(limit + 1);
    endfunction

    // A one-cycle repeat period still needs a 1-bit counter to exist.
    function automatic int RPT_W(input int period);
        return period > 1 ? $clog2(period) : 1;
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch -> 2-FF sync, debounce counter, press/release strobes, hold flag
// and, with DEBOUNCE_BANK_AUTO_REPEAT_EN defined, auto-repeat strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS,
    parameter int HOLD_LIMIT     = HOLD_500MS,
    parameter int REPEAT_PERIOD  = REPEAT_100MS,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_State,
    output logic o_Press,
    output logic o_Release,
    output logic o_Hold,
    output logic o_Repeat
);
    localparam int CW = CNT_W(DEBOUNCE_LIMIT);
    localparam int HW = HOLD_W(HOLD_LIMIT);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold_cnt;
    logic          flip;

    assign flip   = (sync[1] != o_State) && (cnt == CW'(DEBOUNCE_LIMIT - 1));
    assign o_Hold = hold_cnt == HW'(HOLD_LIMIT);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync      <= '0;
            cnt       <= '0;
            o_State   <= 1'b0;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            sync      <= {sync[0], i_Switch ^ 1'(ACTIVE_LOW)};
            cnt       <= (sync[1] == o_State || flip) ? '0 : cnt + 1'b1;
            o_State   <= o_State ^ flip;
            o_Press   <= flip & ~o_State;
            o_Release <= flip & o_State;
            // Clearing on the release edge makes o_Hold fall together with o_Release.
            hold_cnt  <= (!o_State || flip) ? '0 : hold_cnt + HW'(hold_cnt != HW'(HOLD_LIMIT));
        end
    end

`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
    localparam int RW = RPT_W(REPEAT_PERIOD);

    logic [RW-1:0] rpt_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || !o_Hold) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= (rpt_cnt == RW'(REPEAT_PERIOD - 1)) ? '0 : rpt_cnt + 1'b1;
        end
    end

    assign o_Repeat = o_Hold && (rpt_cnt == '0);
`else
    assign o_Repeat = 1'b0;
`endif
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NUM_CH independent debounce channels plus an any-press summary strobe.
// Auto-repeat is built only when DEBOUNCE_BANK_AUTO_REPEAT_EN is defined.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS,
    parameter int HOLD_LIMIT     = HOLD_500MS,
    parameter int REPEAT_PERIOD  = REPEAT_100MS,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_State,
    output logic [NUM_CH-1:0] o_Press,
    output logic [NUM_CH-1:0] o_Release,
    output logic [NUM_CH-1:0] o_Hold,
    output logic [NUM_CH-1:0] o_Repeat,
    output logic              o_Any_Press
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .HOLD_LIMIT    (HOLD_LIMIT),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Switch (i_Switch[g]),
            .o_State  (o_State[g]),
            .o_Press  (o_Press[g]),
            .o_Release(o_Release[g]),
            .o_Hold   (o_Hold[g]),
            .o_Repeat (o_Repeat[g])
        );
    end

    assign o_Any_Press = |o_Press;
endmodule
